// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending controller: FSM states,
// coin encodings, credit width and the coin-to-credit conversion.
package vend_pkg;

  localparam int unsigned CREDIT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CREDIT = 2'd1,
    S_VEND   = 2'd2,
    S_CHANGE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    COIN_25      = 2'b00,
    COIN_50      = 2'b01,
    COIN_1TL     = 2'b10,
    COIN_INVALID = 2'b11
  } coin_t;

  // Coin face value in 25 kr units; the invalid encoding is worth nothing.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] t);
    logic [CREDIT_W-1:0] v;
    v = '0;
    case (coin_t'(t))
      COIN_25:  v = CREDIT_W'(1);
      COIN_50:  v = CREDIT_W'(2);
      COIN_1TL: v = CREDIT_W'(4);
      default:  v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_change_unit.sv
// Change hopper sequencer: loads an amount and pays it out as 25 kr
// pulses on every second cycle, flagging done once the count is spent.
module vend_change_unit
  import vend_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_load,
  input  logic [CREDIT_W-1:0] i_amount,
  output logic                o_change_25,
  output logic [CREDIT_W-1:0] o_count,
  output logic                o_done
);

  logic                r_active;
  logic                r_phase;
  logic                r_pulse;
  logic [CREDIT_W-1:0] r_count;

  // Payout sequencer: a pulse leaves on the cycle after load, then every
  // second cycle; the count drops together with each pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_phase  <= 1'b0;
      r_pulse  <= 1'b0;
      r_count  <= '0;
    end else if (i_load) begin
      r_active <= 1'b1;
      r_phase  <= 1'b0;
      r_pulse  <= 1'b0;
      r_count  <= i_amount;
    end else if (r_active) begin
      if (r_count == '0) begin
        r_active <= 1'b0;
        r_pulse  <= 1'b0;
      end else if (!r_phase) begin
        r_pulse  <= 1'b1;
        r_count  <= r_count - 1'b1;
        r_phase  <= 1'b1;
      end else begin
        r_pulse  <= 1'b0;
        r_phase  <= 1'b0;
      end
    end else begin
      r_pulse <= 1'b0;
    end
  end

  assign o_change_25 = r_pulse;
  assign o_count     = r_count;
  // Done is seen during the final pulse so the controller leaves CHANGE
  // on the very next edge.
  assign o_done      = r_active && (r_count == '0);

endmodule

// File: rtl/vend_controller.sv
// Multi-product vending controller: coin credit accumulation, price
// arbitration, dispenser handshake with timeout, and change/refund payout.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned MAX_CREDIT   = 8,
  parameter int unsigned PRICE0       = 4,
  parameter int unsigned PRICE1       = 3,
  parameter int unsigned PRICE2       = 6,
  parameter int unsigned PRICE3       = 2,
  parameter int unsigned DISP_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel_valid,
  input  logic [1:0]          sel_id,
  input  logic                cancel,
  input  logic                dispense_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                dispense_req,
  output logic [1:0]          dispense_id,
  output logic                coin_reject,
  output logic                insufficient,
  output logic                change_25,
  output logic                vend_done,
  output logic                vend_fail
);

  localparam int unsigned TMO_W = (DISP_TIMEOUT < 2) ? 1 : $clog2(DISP_TIMEOUT);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_req;
  logic [1:0]          r_id;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_coin_reject;
  logic                r_insuff;
  logic                r_done;
  logic                r_fail;

  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic                w_coin_ok;
  logic [CREDIT_W-1:0] w_sel_price;
  logic [CREDIT_W-1:0] w_vend_price;
  logic [CREDIT_W-1:0] w_remainder;
  logic                w_sel_ok;
  logic                w_cancel;
  logic                w_ack;
  logic                w_timeout;
  logic                w_chg_load;
  logic [CREDIT_W-1:0] w_chg_amount;
  logic                w_chg_pulse;
  logic [CREDIT_W-1:0] w_chg_count;
  logic                w_chg_done;

  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] id);
    logic [CREDIT_W-1:0] p;
    p = '0;
    case (id)
      2'd0:    p = CREDIT_W'(PRICE0);
      2'd1:    p = CREDIT_W'(PRICE1);
      2'd2:    p = CREDIT_W'(PRICE2);
      default: p = CREDIT_W'(PRICE3);
    endcase
    return p;
  endfunction

  assign w_coin_val   = coin_value(coin_type);
  assign w_sum        = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_coin_ok    = (coin_t'(coin_type) != COIN_INVALID) &&
                        (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign w_sel_price  = price_of(sel_id);
  assign w_vend_price = price_of(r_id);
  assign w_remainder  = r_credit - w_vend_price;

  // Select is judged against the registered credit, ignoring a same-cycle coin.
  assign w_sel_ok  = sel_valid && (r_state == S_CREDIT) && (r_credit >= w_sel_price);
  assign w_cancel  = cancel && (r_state == S_CREDIT);
  assign w_ack     = (r_state == S_VEND) && r_req && dispense_ack;
  assign w_timeout = (r_state == S_VEND) && !w_ack &&
                     (r_tmo == TMO_W'(DISP_TIMEOUT - 1));

  // The change unit is loaded on the same edge the FSM enters CHANGE.
  assign w_chg_load   = w_cancel || w_timeout || (w_ack && (w_remainder != '0));
  assign w_chg_amount = w_ack ? w_remainder : r_credit;

  vend_change_unit u_change (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_chg_load),
    .i_amount    (w_chg_amount),
    .o_change_25 (w_chg_pulse),
    .o_count     (w_chg_count),
    .o_done      (w_chg_done)
  );

  // Main sequencing FSM with registered handshake and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_credit      <= '0;
      r_req         <= 1'b0;
      r_id          <= '0;
      r_tmo         <= '0;
      r_coin_reject <= 1'b0;
      r_insuff      <= 1'b0;
      r_done        <= 1'b0;
      r_fail        <= 1'b0;
    end else begin
      r_coin_reject <= 1'b0;
      r_insuff      <= 1'b0;
      r_done        <= 1'b0;
      r_fail        <= 1'b0;
      unique case (r_state)
        S_IDLE, S_CREDIT: begin
          if (w_cancel) begin
            r_state       <= S_CHANGE;
            r_coin_reject <= coin_valid;
          end else if (w_sel_ok) begin
            r_state       <= S_VEND;
            r_req         <= 1'b1;
            r_id          <= sel_id;
            r_tmo         <= '0;
            r_coin_reject <= coin_valid;
          end else begin
            if (sel_valid) begin
              r_insuff <= 1'b1;
            end
            if (coin_valid) begin
              if (w_coin_ok) begin
                r_credit <= w_sum[CREDIT_W-1:0];
                r_state  <= S_CREDIT;
              end else begin
                r_coin_reject <= 1'b1;
              end
            end
          end
        end
        S_VEND: begin
          r_coin_reject <= coin_valid;
          if (w_ack) begin
            r_req    <= 1'b0;
            r_done   <= 1'b1;
            r_credit <= w_remainder;
            r_state  <= (w_remainder != '0) ? S_CHANGE : S_IDLE;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_fail  <= 1'b1;
            r_state <= S_CHANGE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_CHANGE: begin
          r_coin_reject <= coin_valid;
          if (w_chg_done) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // While paying out, the visible credit is the change unit's running count.
  assign credit       = (r_state == S_CHANGE) ? w_chg_count : r_credit;
  assign busy         = (r_state == S_VEND) || (r_state == S_CHANGE);
  assign dispense_req = r_req;
  assign dispense_id  = r_id;
  assign coin_reject  = r_coin_reject;
  assign insufficient = r_insuff;
  assign change_25    = w_chg_pulse;
  assign vend_done    = r_done;
  assign vend_fail    = r_fail;

  a_req_only_in_vend: assert property (@(posedge clk) disable iff (reset)
    r_req |-> (r_state == S_VEND));
  a_done_fail_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(r_done && r_fail));

endmodule

// File: doc/vend_controller.md
# vend_controller

Sequencing controller for the coin-operated vending datapath. It accumulates coin credit in 25 kr units and arbitrates product selection against per-product prices. It drives a request/acknowledge handshake to the product dispenser, then pays out change or refunds as a train of 25 kr pulses. It sits between the coin acceptor/keypad and the dispenser and change hopper, and replaces the single-product fixed-price FSM with a multi-product, refund-capable controller.

## Interface
- `MAX_CREDIT`, 8: credit ceiling in 25 kr units (8 = 2 TL); max 15.
- `PRICE0`, 4: product 0 price in 25 kr units (1 TL).
- `PRICE1`, 3: product 1 price (75 kr).
- `PRICE2`, 6: product 2 price (1.50 TL).
- `PRICE3`, 2: product 3 price (50 kr).
- `DISP_TIMEOUT`, 16: cycles `dispense_req` may wait for `dispense_ack` before the vend is aborted.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `coin_valid` in 1: one-cycle coin-inserted strobe.
- `coin_type` in 2: 00 = 25 kr, 01 = 50 kr, 10 = 1 TL, 11 = invalid.
- `sel_valid` in 1: one-cycle product-select strobe.
- `sel_id` in 2: selected product.
- `cancel` in 1: one-cycle refund request.
- `dispense_ack` in 1: dispenser has released the product.
- `credit` out 4: current credit in 25 kr units.
- `busy` out 1: high in VEND or CHANGE.
- `dispense_req` out 1: held high until acknowledged or timed out.
- `dispense_id` out 2: product being vended; stable while `dispense_req` is high.
- `coin_reject` out 1: one-cycle pulse telling the acceptor to return the coin.
- `insufficient` out 1: one-cycle pulse when a select is refused for low credit.
- `change_25` out 1: one-cycle pulse that ejects one 25 kr coin.
- `vend_done` out 1: one-cycle pulse on a successful vend.
- `vend_fail` out 1: one-cycle pulse on a vend timeout.

## Operation
- The controller has four states: IDLE (credit = 0), CREDIT (credit > 0), VEND and CHANGE.
- Synchronous reset applies in any state, including mid-vend and mid-change.
  - State goes to IDLE, `credit` to 0 and all outputs to 0.
  - Pending credit is discarded.
- Coin handling:
  - A coin is accepted only in IDLE or CREDIT, only for `coin_type` != 11, and only if credit + value <= `MAX_CREDIT`.
  - On acceptance, credit += value (1, 2 or 4) and the state becomes CREDIT.
  - Any other coin produces `coin_reject`.
- Select in CREDIT:
  - The select is compared against the registered credit, before any coin arriving in the same cycle is added.
  - If credit >= price: the state becomes VEND and `dispense_req` = 1 with `dispense_id` = `sel_id`. A coin arriving in the same cycle is rejected.
  - Otherwise: `insufficient` pulses, the state is unchanged, and a coin arriving in the same cycle is processed normally.
- Select in IDLE produces an `insufficient` pulse. Select in VEND or CHANGE is ignored.
- Cancel:
  - In CREDIT, cancel moves the state to CHANGE with the full credit. Cancel takes priority over a simultaneous select or coin; the coin is rejected.
  - Cancel is ignored in IDLE, VEND and CHANGE.
- VEND:
  - `dispense_ack` while `dispense_req` is high completes the vend: credit -= price, `vend_done` pulses and `dispense_req` drops.
  - After a completed vend, the next state is CHANGE if the remainder is > 0, otherwise IDLE.
  - The timeout counter starts at 0 on VEND entry. If `DISP_TIMEOUT` cycles pass without an ack: `dispense_req` drops, `vend_fail` pulses, credit is not deducted and the state becomes CHANGE (full refund).
  - Ack and timeout in the same cycle: ack wins.
- CHANGE:
  - One `change_25` pulse is issued every second cycle, and credit decrements by 1 per pulse.
  - When credit reaches 0 the state returns to IDLE.

## Timing
- Reset values: every output is 0.
- Coin/select/cancel strobe at cycle n: the effect is visible on registered outputs (`credit`, `coin_reject`, `insufficient`, `dispense_req`) at n+1.
- `dispense_ack` at cycle m:
  - At m+1: `dispense_req` = 0, `vend_done` = 1, and `credit` shows the remainder.
  - If the remainder is 0, the state is IDLE at m+1.
- Change train: for CHANGE entered at cycle k, `change_25` is high at k+1, k+3, …
  - `credit` decrements in the same cycle as each pulse.
  - After the final pulse at cycle j, the state is IDLE at j+1.
- Timeout: with `dispense_req` first high at cycle r and no ack, `vend_fail` = 1 and the state is CHANGE at r+`DISP_TIMEOUT`.
- Credit width is 4 bits; `MAX_CREDIT` guarantees no overflow, and subtraction never underflows because vend requires credit >= price.

## Structure
- `vend_pkg` holds the state enum (`S_IDLE`, `S_CREDIT`, `S_VEND`, `S_CHANGE`), the `coin_type` encodings, the coin-value function (type → 25 kr units) and the credit width constant.
- Sub-module `vend_change_unit`:
  - Loads the credit and emits the `change_25` train.
  - Signals done back to the controller.
- The top level keeps the main FSM, the price mux and the timeout counter.

## Test plan
- Coins 50, 50 (credit 4), select 0 (price 4), ack 3 cycles later: `dispense_req` for 3 cycles, `vend_done` pulses, credit 0, no `change_25`, state IDLE.
- Coins 1 TL, 50 (credit 6), select 0, immediate ack: credit 2, then two `change_25` pulses two cycles apart, then IDLE.
- Coins 1 TL, 1 TL (credit 8), third coin 25: `coin_reject` pulses and credit stays 8. Invalid type 11 is also rejected.
- Coin 25, select 2 (price 6): `insufficient` pulses and credit stays 1. Cancel: one `change_25` pulse, then IDLE.
- Credit 4, select 1, dispenser never acks: after 16 cycles `vend_fail` pulses, then four `change_25` pulses refund the full credit.
- Reset asserted mid-CHANGE with credit 3: next cycle all outputs 0, credit 0, IDLE, no further `change_25`.
